mdu_seq: RTL
============

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYC, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage pulse, high for mult/multu/div/divu.
REQ-006 mdu_op  input  5  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
REQ-007 rs_val  input  32  forwarded GPR[rs] operand.
REQ-008 rt_val  input  32  forwarded GPR[rt] operand.
REQ-009 d_mdu_use  input  1  D-stage instruction is any MDU op (codes 1-8).
REQ-010 busy  output  1  operation in flight.
REQ-011 mdu_stall  output  1  stall request to the hazard unit.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.
REQ-014 mdu_rd  output  32  read data for mfhi/mflo.

Function
REQ-015 The FSM SHALL have states IDLE, MUL and DIV, plus a down-counter cnt wide enough for max(MULT_CYC, DIV_CYC).
REQ-016 In IDLE with start=1, the block SHALL latch rs_val, rt_val and mdu_op, then enter MUL (op 1/2) or DIV (op 3/4) with cnt=MULT_CYC-1 or DIV_CYC-1.
REQ-017 busy SHALL be high from the edge after start for exactly MULT_CYC (mult) or DIV_CYC (div) cycles.
REQ-018 In MUL/DIV, cnt SHALL decrement each cycle; at cnt=0 the block SHALL write HI/LO and return to IDLE on the same edge, so busy is low in the next cycle.
REQ-019 mult: {hi,lo} SHALL equal the signed 64-bit product. multu: {hi,lo} SHALL equal the unsigned 64-bit product.
REQ-020 div: lo SHALL be the signed quotient truncated toward zero, and hi SHALL be the remainder with the dividend's sign. divu: lo and hi SHALL be the unsigned quotient and remainder.
REQ-021 HI/LO SHALL hold their old values while busy and SHALL change only at completion.
REQ-022 mthi/mtlo in IDLE without start SHALL write rs_val to hi/lo at the next edge.
REQ-023 mdu_rd SHALL be combinational: hi when mdu_op=5, lo when mdu_op=6, otherwise 0.
REQ-024 mdu_stall SHALL be combinational and equal d_mdu_use AND (start OR busy).
REQ-025 start, mthi and mtlo asserted while busy SHALL be ignored; the hazard unit guarantees this never occurs.
REQ-026 Opcodes 0, 5, 6 and 9-31 SHALL NOT change state or HI/LO.
REQ-027 After completion, a start asserted in the first IDLE cycle SHALL be accepted, giving back-to-back operation with one idle cycle between busy windows.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, cnt=0, busy=0, hi=0 and lo=0, including mid-operation, and the in-flight result SHALL be discarded.
REQ-029 After reset release, the first rising edge SHALL behave as the IDLE state.

Configuration
REQ-030 With MDU_DIV0_GUARD_EN defined, div/divu with rt_val=0 SHALL still take DIV_CYC busy cycles and then leave hi/lo unchanged.
REQ-031 Without MDU_DIV0_GUARD_EN, div/divu by zero SHALL complete with hi=rs_val and lo=32'hFFFFFFFF.

Verification
REQ-032 mult with rs=32'hFFFFFFFE (-2) and rt=3 -> busy high 5 cycles, then hi=32'hFFFFFFFF and lo=32'hFFFFFFFA.
REQ-033 divu with rs=100 and rt=7 -> busy high 10 cycles, then lo=14 and hi=2; div with rs=-7 and rt=2 -> lo=-3 and hi=-1.
REQ-034 Start mult while d_mdu_use=1 with mflo in D -> mdu_stall high in the start cycle and all 5 busy cycles, low after; mflo then reads the new lo.
REQ-035 Assert reset at the 3rd busy cycle of a div -> busy=0 and hi=lo=0 immediately; no later write occurs.
REQ-036 mthi with rs=32'h12345678 in IDLE -> hi=32'h12345678 next edge; a following mfhi gives mdu_rd=32'h12345678.
REQ-037 div with rt=0 and rs=9, HI/LO pre-set to 1/2 -> guard on: hi=1, lo=2; guard off: hi=9, lo=32'hFFFFFFFF.

Source files
------------

// File: rtl/mdu_seq_if.sv
// mdu_seq handshake/bus bundle: E-stage request, D-stage use flag,
// and status/result outputs; master drives requests, slave is the MDU.
interface mdu_seq_if;
  logic        start;
  logic [4:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_mdu_use;
  logic        busy;
  logic        mdu_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_rd;

  modport master (
    output start, mdu_op, rs_val, rt_val, d_mdu_use,
    input  busy, mdu_stall, hi, lo, mdu_rd
  );

  modport slave (
    input  start, mdu_op, rs_val, rt_val, d_mdu_use,
    output busy, mdu_stall, hi, lo, mdu_rd
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MIPS-style mult/div unit with HI/LO registers.
// Ports: clk, reset (async active-high), bus (mdu_seq_if.slave):
//   start/mdu_op/rs_val/rt_val/d_mdu_use in; busy/mdu_stall/hi/lo/mdu_rd out.
// Option MDU_DIV0_GUARD_EN: divide by zero leaves HI/LO unchanged.
module mdu_seq #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_seq_if.slave   bus
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath on latched operands
  logic [63:0] prod;
  logic        sgn;
  logic [31:0] ma, mb, mb_nz;
  logic [31:0] mq, mr;
  logic [31:0] quo, rem;

  always_comb begin
    if (op_q == OP_MULT)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'd0, a_q} * {32'd0, b_q};
  end

  // Signed divide via magnitudes; -2^31/-1 falls out as 2^31 / rem 0.
  always_comb begin
    sgn   = (op_q == OP_DIV);
    ma    = (sgn && a_q[31]) ? -a_q : a_q;
    mb    = (sgn && b_q[31]) ? -b_q : b_q;
    mb_nz = (mb == 32'd0) ? 32'd1 : mb;
    mq    = ma / mb_nz;
    mr    = ma % mb_nz;
    quo   = (sgn && (a_q[31] ^ b_q[31])) ? -mq : mq;
    rem   = (sgn && a_q[31]) ? -mr : mr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            (bus.mdu_op == OP_MULT),
            (bus.mdu_op == OP_MULTU): begin
              state_d = MUL;
              cnt_d   = CW'(MULT_CYC - 1);
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              op_d    = bus.mdu_op;
            end
            (bus.mdu_op == OP_DIV),
            (bus.mdu_op == OP_DIVU): begin
              state_d = DIV;
              cnt_d   = CW'(DIV_CYC - 1);
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              op_d    = bus.mdu_op;
            end
            default: ;
          endcase
        end else if (bus.mdu_op == OP_MTHI) begin
          hi_d = bus.rs_val;
        end else if (bus.mdu_op == OP_MTLO) begin
          lo_d = bus.rs_val;
        end
      end
      MUL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
`ifdef MDU_DIV0_GUARD_EN
            hi_d = hi_q;
            lo_d = lo_q;
`else
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
`endif
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.mdu_stall = bus.d_mdu_use &
                    (bus.start | (state_q != IDLE));
    bus.hi        = hi_q;
    bus.lo        = lo_q;
    bus.mdu_rd    = 32'd0;
    if (bus.mdu_op == OP_MFHI)
      bus.mdu_rd = hi_q;
    else if (bus.mdu_op == OP_MFLO)
      bus.mdu_rd = lo_q;
  end

endmodule
